// File: rtl/caption_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : caption_pkg
//  Purpose  : Shared scan-code constants, glyph codes and FSM state type for
//             the keyboard caption-entry stage.
//  Revision : 1.0 - initial release
// ============================================================================
package caption_pkg;

  // PS/2 set-2 control and prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // The renderer's font draws a blank for 0x7F, so that is our space
  localparam logic [7:0] ASCII_SPACE = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_EXT   = 2'd2
  } state_t;

endpackage : caption_pkg
`default_nettype wire

// File: rtl/scancode_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module   : scancode_to_ascii
//  Purpose  : Combinational map from a set-2 make code to an uppercase letter
//             or the font space glyph; is_char flags a printable key.
//  Revision : 1.0 - initial release
// ============================================================================
module scancode_to_ascii
  import caption_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii,
  output logic       is_char
);

  // Lookup table; zero means "not a printable key"
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h41;  // A
      8'h32: ascii = 8'h42;  // B
      8'h21: ascii = 8'h43;  // C
      8'h23: ascii = 8'h44;  // D
      8'h24: ascii = 8'h45;  // E
      8'h2B: ascii = 8'h46;  // F
      8'h34: ascii = 8'h47;  // G
      8'h33: ascii = 8'h48;  // H
      8'h43: ascii = 8'h49;  // I
      8'h3B: ascii = 8'h4A;  // J
      8'h42: ascii = 8'h4B;  // K
      8'h4B: ascii = 8'h4C;  // L
      8'h3A: ascii = 8'h4D;  // M
      8'h31: ascii = 8'h4E;  // N
      8'h44: ascii = 8'h4F;  // O
      8'h4D: ascii = 8'h50;  // P
      8'h15: ascii = 8'h51;  // Q
      8'h2D: ascii = 8'h52;  // R
      8'h1B: ascii = 8'h53;  // S
      8'h2C: ascii = 8'h54;  // T
      8'h3C: ascii = 8'h55;  // U
      8'h2A: ascii = 8'h56;  // V
      8'h1D: ascii = 8'h57;  // W
      8'h22: ascii = 8'h58;  // X
      8'h35: ascii = 8'h59;  // Y
      8'h1A: ascii = 8'h5A;  // Z
      SC_SPACE: ascii = ASCII_SPACE;
      default: ascii = 8'h00;
    endcase
  end

  assign is_char = (ascii != 8'h00);

endmodule : scancode_to_ascii
`default_nettype wire

// File: rtl/caption_entry.sv
`default_nettype none
// ============================================================================
//  Module   : caption_entry
//  Purpose  : PS/2 scan-code driven edit buffer that commits a packed caption
//             string to the renderer on Enter and reverts to the built-in
//             caption on Esc.
//             "string" is a reserved word, so the committed caption port is
//             named str.
//  Revision : 1.0 - initial release
// ============================================================================
module caption_entry
  import caption_pkg::*;
#(
  parameter int STRING_LENGTH = 5,
  parameter int ARRAY_LEN     = 8 * STRING_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           key_code,
  input  logic                 key_valid,
  output logic [ARRAY_LEN-1:0] str,
  output logic [5:0]           numchar,
  output logic                 ready,
  output logic                 custom,
  output logic [5:0]           edit_count
);

  localparam logic [ARRAY_LEN-1:0] BLANK = {STRING_LENGTH{ASCII_SPACE}};

  state_t               state_q, state_d;
  logic [ARRAY_LEN-1:0] buf_q, buf_d;
  logic [ARRAY_LEN-1:0] str_q, str_d;
  logic [5:0]           edit_count_q, edit_count_d;
  logic [5:0]           numchar_q, numchar_d;
  logic                 custom_q, custom_d;
  logic                 ready_q, ready_d;

  logic [7:0]           lut_ascii;
  logic                 lut_is_char;
  logic                 wr_en;
  logic [5:0]           wr_idx;
  logic [7:0]           wr_char;

  scancode_to_ascii u_lut (
    .code    (key_code),
    .ascii   (lut_ascii),
    .is_char (lut_is_char)
  );

  // Prefix-tracking FSM plus edit/commit actions on each accepted byte
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    str_d        = str_q;
    edit_count_d = edit_count_q;
    numchar_d    = numchar_q;
    custom_d     = custom_q;
    ready_d      = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = edit_count_q;
    wr_char      = ASCII_SPACE;

    if (key_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (key_code == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (key_code == SC_EXT) begin
            state_d = ST_EXT;
          end else if (key_code == SC_ENTER) begin
            str_d     = buf_q;
            numchar_d = edit_count_q;
            custom_d  = 1'b1;
            ready_d   = 1'b1;
          end else if (key_code == SC_BKSP) begin
            if (edit_count_q != 6'd0) begin
              edit_count_d = edit_count_q - 6'd1;
              wr_en        = 1'b1;
              wr_idx       = edit_count_q - 6'd1;
              wr_char      = ASCII_SPACE;
            end
          end else if (key_code == SC_ESC) begin
            custom_d = 1'b0;
          end else if (lut_is_char && (edit_count_q < 6'(STRING_LENGTH))) begin
            edit_count_d = edit_count_q + 6'd1;
            wr_en        = 1'b1;
            wr_idx       = edit_count_q;
            wr_char      = lut_ascii;
          end
        end
        // Release code: swallow the key being released
        ST_BREAK: state_d = ST_IDLE;
        // Extended keys are not used; only track a following release
        ST_EXT:   state_d = (key_code == SC_BREAK) ? ST_BREAK : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Slot 0 sits in the most significant byte
    for (int i = 0; i < STRING_LENGTH; i++) begin
      if (wr_en && (wr_idx == 6'(i))) begin
        buf_d[ARRAY_LEN-1-8*i -: 8] = wr_char;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      buf_q        <= BLANK;
      str_q        <= BLANK;
      edit_count_q <= 6'd0;
      numchar_q    <= 6'd0;
      custom_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      str_q        <= str_d;
      edit_count_q <= edit_count_d;
      numchar_q    <= numchar_d;
      custom_q     <= custom_d;
      ready_q      <= ready_d;
    end
  end

  assign str        = str_q;
  assign numchar    = numchar_q;
  assign ready      = ready_q;
  assign custom     = custom_q;
  assign edit_count = edit_count_q;

endmodule : caption_entry
`default_nettype wire

// File: tb/tb_caption_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_caption_entry
//  Purpose  : Self-checking bench for caption_entry (STRING_LENGTH = 5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_caption_entry;

  localparam int STRING_LENGTH = 5;
  localparam int ARRAY_LEN     = 8 * STRING_LENGTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           key_code = 8'h00;
  logic                 key_valid = 1'b0;
  logic [ARRAY_LEN-1:0] str;
  logic [5:0]           numchar;
  logic                 ready;
  logic                 custom;
  logic [5:0]           edit_count;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;

  caption_entry #(.STRING_LENGTH(STRING_LENGTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .str        (str),
    .numchar    (numchar),
    .ready      (ready),
    .custom     (custom),
    .edit_count (edit_count)
  );

  always #5 clk = ~clk;

  // Count cycles on which ready is high
  always @(negedge clk) if (ready) ready_cnt = ready_cnt + 1;

  typedef struct {
    logic [127:0]         seq;   // byte 0 is the most significant used byte
    int                   n;
    logic [ARRAY_LEN-1:0] exp_str;
    logic [5:0]           exp_num;
    logic                 exp_custom;
    logic [5:0]           exp_edit;
    int                   exp_pulses;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    key_code  = b;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{128'h4DF04D_1CF01C_2DF02D_43F043_1BF01B_5A, 16,
                40'h50_41_52_49_53, 6'd5, 1'b1, 6'd5, 1};
    vecs[1] = '{128'h1C_32_21_23_24_2B_34_5A, 8,
                40'h41_42_43_44_45, 6'd5, 1'b1, 6'd5, 1};
    vecs[2] = '{128'h1C_32_66_29_5A, 5,
                40'h41_7F_7F_7F_7F, 6'd2, 1'b1, 6'd2, 1};
    vecs[3] = '{128'h1C_32_5A_76, 4,
                40'h41_42_7F_7F_7F, 6'd2, 1'b0, 6'd2, 1};
    vecs[4] = '{128'hE0_75_E0_F0_75_1C_5A, 7,
                40'h41_7F_7F_7F_7F, 6'd1, 1'b1, 6'd1, 1};
    vecs[5] = '{128'h5A, 1,
                40'h7F_7F_7F_7F_7F, 6'd0, 1'b1, 6'd0, 1};
    vecs[6] = '{128'h66_66_1C, 3,
                40'h7F_7F_7F_7F_7F, 6'd0, 1'b0, 6'd1, 0};
    vecs[7] = '{128'h0E_1C_5A, 3,
                40'h41_7F_7F_7F_7F, 6'd1, 1'b1, 6'd1, 1};
    vecs[8] = '{128'h1C_76, 2,
                40'h7F_7F_7F_7F_7F, 6'd0, 1'b0, 6'd1, 0};
    vecs[9] = '{128'h1C_5A_32_5A, 4,
                40'h41_42_7F_7F_7F, 6'd2, 1'b1, 6'd2, 2};

    // Reset values
    do_reset();
    check("reset_str", 64'(str), 64'h7F7F7F7F7F);
    check("reset_numchar", 64'(numchar), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_custom", 64'(custom), 64'd0);
    check("reset_edit", 64'(edit_count), 64'd0);

    // Table-driven sequences, bytes sent back-to-back
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int j = 0; j < vecs[v].n; j++) begin
        send(vecs[v].seq[8*(vecs[v].n-1-j) +: 8]);
      end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_str", v), 64'(str), 64'(vecs[v].exp_str));
      check($sformatf("v%0d_numchar", v), 64'(numchar), 64'(vecs[v].exp_num));
      check($sformatf("v%0d_custom", v), 64'(custom), 64'(vecs[v].exp_custom));
      check($sformatf("v%0d_edit", v), 64'(edit_count), 64'(vecs[v].exp_edit));
      check($sformatf("v%0d_pulses", v), 64'(ready_cnt), 64'(vecs[v].exp_pulses));
    end

    // Latency: effect visible right after the key_valid edge; ready is one cycle
    do_reset();
    send(8'h1C);
    check("lat_edit", 64'(edit_count), 64'd1);
    send(8'h5A);
    check("lat_ready_hi", 64'(ready), 64'd1);
    check("lat_str_at_ready", 64'(str), 64'h417F7F7F7F);
    check("lat_num_at_ready", 64'(numchar), 64'd1);
    @(posedge clk);
    #1;
    check("lat_ready_lo", 64'(ready), 64'd0);

    // Bytes without key_valid are ignored, including a would-be break prefix
    do_reset();
    key_code = 8'hF0;
    repeat (3) @(posedge clk);
    #1;
    key_code = 8'h1C;
    repeat (2) @(posedge clk);
    #1;
    check("novalid_edit", 64'(edit_count), 64'd0);
    send(8'h32);
    check("novalid_then_b", 64'(edit_count), 64'd1);

    // Reset mid-sequence while in BREAK aborts the release handling
    do_reset();
    send(8'h32);
    send(8'h5A);
    send(8'hF0);
    rst_n = 1'b0;
    #1;
    check("midrst_str", 64'(str), 64'h7F7F7F7F7F);
    check("midrst_numchar", 64'(numchar), 64'd0);
    check("midrst_custom", 64'(custom), 64'd0);
    check("midrst_edit", 64'(edit_count), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_cnt = 0;
    send(8'h1C);
    send(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_after_num", 64'(numchar), 64'd1);
    check("midrst_after_str", 64'(str), 64'h417F7F7F7F);
    check("midrst_after_pulses", 64'(ready_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_caption_entry
`default_nettype wire

// File: doc/caption_entry.md
Name: caption_entry

Overview:
- Keyboard-driven text-entry stage that sits directly upstream of the caption string renderer.
- Consumes PS/2 set-2 scan-code bytes from the keyboard decoder and maintains an edit buffer of uppercase letters and spaces.
- On Enter, commits the buffer as a packed string with a ready pulse, a character count and a custom-caption enable, in exactly the format the renderer latches.
- Esc reverts the renderer to its built-in caption.

Parameters:
- STRING_LENGTH, 5, maximum characters in the caption; must match the renderer's STRING_LENGTH.
- ARRAY_LEN, 8*STRING_LENGTH, packed string width (derived; not overridden).

Ports:
- clk  in  1  pixel clock shared with the renderer
- rst_n  in  1  asynchronous, active-low reset
- key_code  in  8  scan-code byte from the PS/2 decoder
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- string  out  ARRAY_LEN  committed caption; character 0 in [ARRAY_LEN-1:ARRAY_LEN-8]
- numchar  out  6  committed character count, 0..STRING_LENGTH
- ready  out  1  one-cycle pulse; string and numchar are valid on the same cycle
- custom  out  1  level; high selects the committed caption in the renderer
- edit_count  out  6  live edit-buffer length, for a cursor/debug display

Behaviour:
- Reset (async, rst_n=0):
  - string = all 8'h7F (space), numchar=0, ready=0, custom=0, edit_count=0.
  - Edit buffer = all 8'h7F; FSM enters IDLE.
- FSM states:
  - IDLE: on key_valid, F0 -> BREAK; E0 -> EXT; any other code -> decode and act, stay IDLE.
  - BREAK: the next key_valid byte is discarded, -> IDLE. This drops key releases.
  - EXT: next byte F0 -> BREAK; any other byte is discarded, -> IDLE. Extended keys are ignored.
  - Bytes arriving with key_valid=0 are ignored in every state.
- Decode in IDLE:
  - Letters (set-2): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A -> ASCII 8'h41..8'h5A.
  - Space 29 -> 8'h7F (the font's space glyph).
  - Append: if edit_count < STRING_LENGTH, write the char at slot edit_count, then edit_count+1. If full, silently drop.
  - Backspace 66: if edit_count > 0, decrement and write 8'h7F to the vacated slot. At empty, no-op.
  - Enter 5A: copy the edit buffer to string and edit_count to numchar; set custom=1; pulse ready=1 for exactly one cycle. Edit buffer is retained. Commit is allowed when empty (numchar=0).
  - Esc 76: custom=0. The edit buffer and string are unchanged; no ready pulse.
  - Unmapped codes: ignored.
- Latency and timing:
  - All outputs are registered.
  - The effect of a byte is visible on the clk edge after its key_valid cycle; ready rises on that edge and is low on the next.
  - Back-to-back key_valid on consecutive cycles must be handled with no byte loss.
- Packing: slot i occupies [ARRAY_LEN-1-8i : ARRAY_LEN-8-8i]. Unused slots always hold 8'h7F.
- Reset asserted mid-sequence (e.g. while in BREAK) aborts the sequence; the next byte after release is decoded from IDLE.

Decomposition:
- Package caption_pkg:
  - Scan-code constants (SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, SC_ESC=76, SC_SPACE=29).
  - ASCII_SPACE=8'h7F.
  - FSM state enum.
- One sub-module, scancode_to_ascii: a combinational lookup giving an 8-bit code plus an is_char flag.
- The FSM, edit buffer and commit logic stay in caption_entry.

Test Plan:
- Send 4D,F0,4D, 1C,F0,1C, 2D,F0,2D, 43,F0,43, 1B,F0,1B, 5A -> one ready pulse; string=50_41_52_49_53; numchar=5; custom=1.
- Type 7 letters with STRING_LENGTH=5 (A..G), then Enter -> string=41_42_43_44_45; numchar=5; F and G dropped.
- Send 1C, 32, 66, 29, 5A -> string=41_7F_7F_7F_7F; numchar=2 (A, then space).
- Commit "AB", then send 76 -> custom=0; string still 41_42_7F_7F_7F; no ready pulse.
- Send E0,75 (up arrow), E0,F0,75, then 1C,5A -> only A is recorded; numchar=1.
- Assert rst_n=0 right after F0, release, send 1C,5A -> numchar=1; string starts 41; all outputs reset to their reset values during reset.
